// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator (sync, active video, coordinates, strobes)
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = 10
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic             pix_en,
    output logic             h_sync,
    output logic             v_sync,
    output logic             display_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_width_check
            $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1) begin : g_param_check
            $error("vga_timing_gen: every timing parameter must be >= 1");
        end
    endgenerate

    // Sync windows end before the back porch, so every constant fits in CNT_W bits.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             de_q, de_d, vb_q, vb_d;
    logic             ls_q, ls_d, fs_q, fs_d;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        vb_d = vb_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (reset) begin
            x_d  = H_LAST;
            y_d  = V_LAST;
            hs_d = ~HS_POL;
            vs_d = ~VS_POL;
            de_d = 1'b0;
            vb_d = 1'b1;
        end else if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            // Decodes use the position being loaded so all outputs stay aligned.
            hs_d = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
            vs_d = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
            de_d = (x_d < H_ACT) && (y_d < V_ACT);
            vb_d = (y_d >= V_ACT);
            ls_d = (x_d == '0);
            fs_d = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge clock_25) begin
        x_q  <= x_d;
        y_q  <= y_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        vb_q <= vb_d;
        ls_q <= ls_d;
        fs_q <= fs_d;
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign display_on  = de_q;
    assign vblank      = vb_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen, default and small configurations
module tb_vga_timing_gen;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit vb;
        bit ls;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pix_en;

    logic       hs0, vs0, de0, ls0, fs0, vb0;
    logic [9:0] px0, py0;
    logic       hs1, vs1, de1, ls1, fs1, vb1;
    logic [2:0] px1, py1;

    vga_timing_gen u_dut0 (
        .clock_25(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(hs0), .v_sync(vs0), .display_on(de0),
        .pixel_x(px0), .pixel_y(py0),
        .line_start(ls0), .frame_start(fs0), .vblank(vb0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3)
    ) u_dut1 (
        .clock_25(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(hs1), .v_sync(vs1), .display_on(de1),
        .pixel_x(px1), .pixel_y(py1),
        .line_start(ls1), .frame_start(fs1), .vblank(vb1)
    );

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference: the raster is a linear pixel index pos in [0, H_TOTAL*V_TOTAL).
    function automatic exp_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                   input bit hp, vp, input int pos, input bit adv);
        exp_t e;
        int ht;
        ht   = ha + hf + hsw + hb;
        e.x  = pos % ht;
        e.y  = pos / ht;
        e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : !hp;
        e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : !vp;
        e.de = (e.x < ha) && (e.y < va);
        e.vb = (e.y >= va);
        e.ls = adv && (e.x == 0);
        e.fs = adv && (pos == 0);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input int x, y,
                           input bit hs, vs, de, vb, ls, fs);
        check({tag, ".pixel_x"}, x, e.x);
        check({tag, ".pixel_y"}, y, e.y);
        check({tag, ".h_sync"}, int'(hs), int'(e.hs));
        check({tag, ".v_sync"}, int'(vs), int'(e.vs));
        check({tag, ".display_on"}, int'(de), int'(e.de));
        check({tag, ".vblank"}, int'(vb), int'(e.vb));
        check({tag, ".line_start"}, int'(ls), int'(e.ls));
        check({tag, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    // Monitor: every clock edge presents a new output word from each DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare("dflt", e, int'(px0), int'(py0), hs0, vs0, de0, vb0, ls0, fs0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("small", e, int'(px1), int'(py1), hs1, vs1, de1, vb1, ls1, fs1);
            end
        end
    end

    localparam int TOT0 = 800 * 525;
    localparam int TOT1 = 8 * 6;
    localparam int N_CYC = 6000;

    int  pos0, pos1;
    bit  adv;
    bit  r, en;

    task automatic step(input bit rst_i, input bit en_i);
        reset  = rst_i;
        pix_en = en_i;
        if (rst_i) begin
            pos0 = TOT0 - 1;
            pos1 = TOT1 - 1;
            adv  = 1'b0;
        end else if (en_i) begin
            pos0 = (pos0 + 1) % TOT0;
            pos1 = (pos1 + 1) % TOT1;
            adv  = 1'b1;
        end else begin
            adv  = 1'b0;
        end
        q0.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, pos0, adv));
        q1.push_back(model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, pos1, adv));
    endtask

    initial begin
        pos0 = 0;
        pos1 = 0;
        step(1'b1, 1'b0);
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            if (c < 3) begin
                r = 1'b1; en = 1'b0;
            end else if (c < 6) begin
                r = 1'b0; en = 1'b0;
            end else if (c < 1900) begin
                r = 1'b0; en = 1'b1;
            end else if (c < 3600) begin
                r  = (c == 3001);
                en = c[0];
            end else begin
                r  = ($urandom_range(0, 499) == 0);
                en = ($urandom_range(0, 3) != 0);
            end
            step(r, en);
        end
        @(negedge clk);
        step(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained0", q0.size(), 0);
        check("scoreboard_drained1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
